// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage core pipeline
module pipe_hazard_ctrl #(
  parameter int BR_PENALTY  = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_mem_rd,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        err_clr,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_hold,
  output logic        idex_bubble,
  output logic        exmem_hold,
  output logic        bus_err,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  ret_state_q, ret_state_d;
  logic [2:0]  fl_cnt_q, fl_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic memw, lu;
  logic freeze, do_run, do_flush, flush_inc, timeout_hit;
  logic pc_hold_c, ifid_hold_c, ifid_flush_c, idex_bubble_c;

  assign memw = dmem_req & ~dmem_ready;
  assign lu   = ex_mem_rd & (ex_rd_addr != 5'd0) &
                ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                 (id_rs2_used & (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    state_d       = state_q;
    ret_state_d   = ret_state_q;
    fl_cnt_d      = fl_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    freeze        = 1'b0;
    do_run        = 1'b0;
    do_flush      = 1'b0;
    flush_inc     = 1'b0;
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;

    case (state_q)
      S_RUN: begin
        if (memw) begin
          freeze      = 1'b1;
          state_d     = S_MEM_WAIT;
          ret_state_d = S_RUN;
          wait_cnt_d  = 8'd1;
        end else begin
          do_run = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (!dmem_ready) begin
          freeze     = 1'b1;
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end else if (ret_state_q == S_FLUSH) begin
          do_flush = 1'b1;
        end else begin
          do_run = 1'b1;
        end
      end
      S_FLUSH: begin
        // A stalled MEM access freezes the flush sequence; fl_cnt resumes afterwards.
        if (memw) begin
          freeze      = 1'b1;
          state_d     = S_MEM_WAIT;
          ret_state_d = S_FLUSH;
          wait_cnt_d  = 8'd1;
        end else begin
          do_flush = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (do_run) begin
      state_d = S_RUN;
      if (ex_branch_taken) begin
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        flush_inc     = 1'b1;
        if (BR_PENALTY > 1) begin
          state_d  = S_FLUSH;
          fl_cnt_d = 3'(BR_PENALTY - 1);
        end
      end else if (lu) begin
        pc_hold_c     = 1'b1;
        ifid_hold_c   = 1'b1;
        idex_bubble_c = 1'b1;
      end
    end

    if (do_flush) begin
      ifid_flush_c = 1'b1;
      fl_cnt_d     = fl_cnt_q - 3'd1;
      state_d      = (fl_cnt_q <= 3'd1) ? S_RUN : S_FLUSH;
    end

    if (freeze) begin
      pc_hold_c   = 1'b1;
      ifid_hold_c = 1'b1;
    end
  end

  assign timeout_hit = freeze & (wait_cnt_d == 8'(MEM_TIMEOUT));

  always_comb begin
    bus_err_d   = timeout_hit ? 1'b1 : (err_clr ? 1'b0 : bus_err_q);
    stall_cnt_d = (pc_hold_c && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_RUN;
      ret_state_q <= S_RUN;
      fl_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      fl_cnt_q    <= fl_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Holds are gated by rstn so they release the instant reset is asserted.
  assign pc_hold     = rstn & pc_hold_c;
  assign ifid_hold   = rstn & ifid_hold_c;
  assign ifid_flush  = rstn & ifid_flush_c;
  assign idex_hold   = rstn & freeze;
  assign idex_bubble = rstn & idex_bubble_c;
  assign exmem_hold  = rstn & freeze;
  assign bus_err     = bus_err_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_mem_rd = 1'b0;
  logic        ex_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0, err_clr = 1'b0;
  logic        pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, bus_err;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  typedef struct packed {
    logic [6:0]  o;   // {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, bus_err}
    logic [31:0] sc;
    logic [15:0] fc;
  } exp_t;

  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1100100;
  localparam logic [6:0] O_BR    = 7'b0010100;
  localparam logic [6:0] O_FL    = 7'b0010000;
  localparam logic [6:0] O_FRZ   = 7'b1101010;
  localparam logic [6:0] O_FRZ_E = 7'b1101011;

  exp_t exp_q[$];
  int   id_q[$];
  int   vec_cnt = 0;
  int   miss_cnt = 0;
  int   issued = 0;

  pipe_hazard_ctrl #(.BR_PENALTY(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_mem_rd(ex_mem_rd), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .err_clr(err_clr),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_bubble(idex_bubble), .exmem_hold(exmem_hold),
    .bus_err(bus_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic vec(input logic r, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic mrd,
                     input logic [4:0] exrd, input logic br, input logic req,
                     input logic rdy, input logic clr, input logic [6:0] o,
                     input logic [31:0] sc, input logic [15:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    rstn = r; id_rs1_addr = rs1; id_rs1_used = u1; id_rs2_addr = rs2; id_rs2_used = u2;
    ex_mem_rd = mrd; ex_rd_addr = exrd; ex_branch_taken = br;
    dmem_req = req; dmem_ready = rdy; err_clr = clr;
    e.o = o; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    id_q.push_back(issued);
    issued++;
  endtask

  initial begin : monitor
    exp_t e, a;
    int   id;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        a.o  = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, bus_err};
        a.sc = stall_cnt;
        a.fc = flush_cnt;
        vec_cnt++;
        if (a !== e) begin
          miss_cnt++;
          $display("FAIL vec%0d: got outs=%b stall=%0d flush=%0d, want outs=%b stall=%0d flush=%0d",
                   id, a.o, a.sc, a.fc, e.o, e.sc, e.fc);
        end
      end
    end
  end

  initial begin : driver
    //   rstn rs1 u1 rs2 u2 mrd exrd br req rdy clr  outs     stall flush
    vec(0, 0, 0, 0, 0, 1, 5, 1, 1, 0, 0, O_NONE,  0, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, 0);
    // load-use on rs2, then bubble clears ex_mem_rd
    vec(1, 3, 1, 5, 1, 1, 5, 0, 0, 0, 0, O_LU,    0, 0);
    vec(1, 3, 1, 5, 1, 0, 5, 0, 0, 0, 0, O_NONE,  1, 0);
    // x0 destination and unused rs1 never stall; used rs1 does
    vec(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, O_NONE,  1, 0);
    vec(1, 7, 0, 2, 1, 1, 7, 0, 0, 0, 0, O_NONE,  1, 0);
    vec(1, 7, 1, 2, 1, 1, 7, 0, 0, 0, 0, O_LU,    1, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  2, 0);
    // taken branch, penalty 2
    vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_BR,    2, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_FL,    2, 1);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  2, 1);
    // three-cycle memory wait
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ,   2, 1);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ,   3, 1);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ,   4, 1);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_NONE,  5, 1);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  5, 1);
    // memw + load-use + branch together
    vec(1, 0, 0, 5, 1, 1, 5, 1, 1, 0, 0, O_FRZ,   5, 1);
    vec(1, 0, 0, 5, 1, 1, 5, 1, 1, 0, 0, O_FRZ,   6, 1);
    vec(1, 0, 0, 5, 1, 1, 5, 1, 1, 1, 0, O_BR,    7, 1);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_FL,    7, 2);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  7, 2);
    // memory wait inside FLUSH resumes the flush on release
    vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_BR,    7, 2);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ,   7, 3);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_FL,    8, 3);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  8, 3);
    // timeout at 4 MEM_WAIT cycles, err_clr, then reset mid-wait
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ,   8, 3);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ,   9, 3);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ,  10, 3);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ,  11, 3);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ_E,12, 3);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_FRZ_E,13, 3);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ,  14, 3);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_NONE,  0, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, 0);
    // reset mid-FLUSH
    vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_BR,    0, 0);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, 0);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      miss_cnt++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V core.
- Decides each cycle whether to advance, hold, bubble or flush the PC, IF/ID, ID/EX and EX/MEM registers.
- Covers three hazard types: load-use hazards, taken branches/jumps resolved in EX, and a data memory that does not answer in one cycle.
- Keeps saturating stall and flush event counters.

Parameters:
- BR_PENALTY, 1: number of cycles IF/ID is flushed after a taken branch (1..7); covers extra fetch latency.
- MEM_TIMEOUT, 255: number of MEM_WAIT cycles without dmem_ready before bus_err is set (1..255).

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- id_rs1_addr  in  5  rs1 of the instruction in ID
- id_rs2_addr  in  5  rs2 of the instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_mem_rd  in  1  the instruction in EX is a load (ID/EX mem_rd output)
- ex_rd_addr  in  5  destination register of the EX instruction
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- dmem_req  in  1  MEM stage is issuing a data memory access
- dmem_ready  in  1  data memory completes the access this cycle
- err_clr  in  1  clears bus_err
- pc_hold  out  1  PC keeps its value
- ifid_hold  out  1  IF/ID keeps its value
- ifid_flush  out  1  IF/ID loads a NOP
- idex_hold  out  1  ID/EX keeps its value
- idex_bubble  out  1  ID/EX control fields load 0
- exmem_hold  out  1  EX/MEM keeps its value
- bus_err  out  1  sticky memory-timeout flag
- stall_cnt  out  32  cycles with pc_hold=1
- flush_cnt  out  16  taken-branch flush events

Behaviour:
- FSM states:
  - RUN (reset state).
  - MEM_WAIT.
  - FLUSH, with a 3-bit counter fl_cnt.
- Wait counter: 8-bit wait_cnt.
- Outputs are a combinational decode of the state and the inputs.
- While rstn=0:
  - State is RUN; fl_cnt, wait_cnt, bus_err, stall_cnt and flush_cnt are all 0.
  - All hold/flush/bubble outputs are forced to 0.
- Hazard terms:
  - memw = dmem_req & ~dmem_ready
  - lu = ex_mem_rd & (ex_rd_addr != 0) & ((id_rs1_used & id_rs1_addr == ex_rd_addr) | (id_rs2_used & id_rs2_addr == ex_rd_addr))
- RUN decode (priority order; first match wins):
  1. memw: assert pc_hold, ifid_hold, idex_hold and exmem_hold. No bubble or flush. Next state MEM_WAIT, wait_cnt=1.
  2. ex_branch_taken: assert ifid_flush and idex_bubble. flush_cnt +1. If BR_PENALTY > 1, next state FLUSH with fl_cnt = BR_PENALTY-1.
  3. lu: assert pc_hold, ifid_hold and idex_bubble for exactly this cycle. There is no state change; the bubble clears ex_mem_rd the next cycle.
  4. Otherwise all outputs are 0.
- MEM_WAIT:
  - While dmem_ready=0: all four holds asserted; wait_cnt increments and saturates at 255.
  - When wait_cnt == MEM_TIMEOUT: set bus_err. The state stays MEM_WAIT, because the core stays frozen until ready or reset.
  - In the cycle dmem_ready=1: evaluate the RUN decode rows 2-4 in this same cycle (no extra latency), then go to RUN or FLUSH.
  - A branch that arrived during the wait is therefore flushed exactly once, on release.
- FLUSH:
  - Assert ifid_flush only; ID/EX advances normally.
  - fl_cnt decrements; return to RUN when fl_cnt==1.
  - memw in FLUSH takes priority: freeze as in MEM_WAIT, and resume FLUSH with fl_cnt unchanged afterwards (store the return state).
  - ex_branch_taken is ignored in FLUSH, because EX holds a bubble.
- bus_err:
  - Set by the timeout condition; cleared by err_clr.
  - Set wins if both occur in the same cycle.
- Counters:
  - stall_cnt increments on every cycle with pc_hold=1, including MEM_WAIT cycles.
  - Both stall_cnt and flush_cnt saturate at all-ones.
- x0 never causes a load-use stall.
- Asynchronous reset mid-MEM_WAIT or mid-FLUSH returns to RUN immediately and releases all holds.

Test Plan:
- Load-use: lw x5 in EX (ex_mem_rd=1, ex_rd_addr=5), ID has rs2=5 with id_rs2_used=1 -> one cycle of pc_hold=ifid_hold=idex_bubble=1; with ex_mem_rd=0 the next cycle, all outputs are 0; stall_cnt=1.
- x0 and unused operand: ex_rd_addr=0 matching rs1=0, and separately rs1 matching with id_rs1_used=0 -> no stall.
- Branch with BR_PENALTY=2: ex_branch_taken pulse -> ifid_flush high for 2 cycles, idex_bubble high for the first cycle only, flush_cnt=1.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all four holds high for 3 cycles and low on the ready cycle; stall_cnt=3.
- Simultaneous: memw, lu and ex_branch_taken all high, ready after 2 cycles -> freeze for 2 cycles, then on the ready cycle ifid_flush=idex_bubble=1 with no load-use stall; flush_cnt=1.
- Timeout with MEM_TIMEOUT=4: dmem_ready held at 0 -> bus_err rises on the 4th wait cycle and stays high; err_clr pulse -> bus_err=0; rstn pulse mid-wait -> all outputs 0 and state RUN.
